// File: rtl/formula_pkg.sv
// Shared types and the single-bit restoring step used by the isqrt pipeline.
// Widths follow the 32-bit operand / 16-bit root datapath.
package formula_pkg;

    localparam int ARG_W       = 32;
    localparam int RES_W       = 32;
    localparam int SQRT_W      = 16;
    localparam int SQRT_STAGES = 16;
    localparam int REM_W       = SQRT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SQRT,
        OUTPUT
    } state_t;

    typedef struct packed {
        logic [REM_W-1:0]  rem;
        logic [SQRT_W-1:0] root;
    } step_t;

    // One restoring iteration: bring down two operand bits, try root*4+1.
    function automatic step_t isqrt_step(
        input logic [REM_W-1:0]  rem,
        input logic [SQRT_W-1:0] root,
        input logic [1:0]        two
    );
        logic [REM_W-1:0] rem_s;
        logic [REM_W-1:0] trial;
        step_t            r;
        rem_s = (rem << 2) | {{(REM_W-2){1'b0}}, two};
        trial = {root, 2'b01};
        if (rem_s >= trial) begin
            r.rem  = rem_s - trial;
            r.root = (root << 1) | {{(SQRT_W-1){1'b0}}, 1'b1};
        end else begin
            r.rem  = rem_s;
            r.root = root << 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/formula_1_impl_1_isqrt.sv
// Fully pipelined floor square root: an input capture register followed
// by one restoring stage per root bit; the valid bit rides with the data.
module isqrt
    import formula_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              x_vld,
    input  logic [ARG_W-1:0]  x,
    output logic              y_vld,
    output logic [SQRT_W-1:0] y
);

    localparam int LAST = SQRT_STAGES - 1;

    logic              vld_q  [0:SQRT_STAGES];
    logic              vld_d  [0:SQRT_STAGES];
    logic [SQRT_W-1:0] root_q [0:SQRT_STAGES];
    logic [SQRT_W-1:0] root_d [0:SQRT_STAGES];
    logic [ARG_W-1:0]  x_q    [0:LAST];
    logic [ARG_W-1:0]  x_d    [0:LAST];
    logic [REM_W-1:0]  rem_q  [0:LAST];
    logic [REM_W-1:0]  rem_d  [0:LAST];

    // Next value of every stage, each computed from its predecessor.
    always_comb begin
        step_t s;
        s         = '0;
        vld_d[0]  = x_vld;
        x_d[0]    = x;
        rem_d[0]  = '0;
        root_d[0] = '0;
        for (int k = 1; k <= LAST; k++) begin
            s         = isqrt_step(rem_q[k-1], root_q[k-1],
                                   x_q[k-1][ARG_W-1 -: 2]);
            vld_d[k]  = vld_q[k-1];
            x_d[k]    = x_q[k-1] << 2;
            rem_d[k]  = s.rem;
            root_d[k] = s.root;
        end
        s                   = isqrt_step(rem_q[LAST], root_q[LAST],
                                         x_q[LAST][ARG_W-1 -: 2]);
        vld_d[SQRT_STAGES]  = vld_q[LAST];
        root_d[SQRT_STAGES] = s.root;
    end

    // Pipeline registers; reset clears data as well so nothing unknown survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '{default: 1'b0};
            root_q <= '{default: '0};
            x_q    <= '{default: '0};
            rem_q  <= '{default: '0};
        end else begin
            vld_q  <= vld_d;
            root_q <= root_d;
            x_q    <= x_d;
            rem_q  <= rem_d;
        end
    end

    assign y_vld = vld_q[SQRT_STAGES];
    assign y     = root_q[SQRT_STAGES];

endmodule

// File: rtl/formula_1_impl_1.sv
// Sum of three floor square roots behind a valid-only request/response port.
// One request in flight; requests arriving outside IDLE are dropped.
module formula_1_impl_1
    import formula_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    input  logic [ARG_W-1:0] a,
    input  logic [ARG_W-1:0] b,
    input  logic [ARG_W-1:0] c,
    output logic             res_vld,
    output logic [RES_W-1:0] res
);

    state_t            state_q, state_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              x_vld;
    logic              ya_vld, yb_vld, yc_vld;
    logic [SQRT_W-1:0] ya, yb, yc;
    logic              all_vld;

    isqrt u_sqrt_a (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(a),
        .y_vld(ya_vld), .y(ya)
    );

    isqrt u_sqrt_b (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(b),
        .y_vld(yb_vld), .y(yb)
    );

    isqrt u_sqrt_c (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(c),
        .y_vld(yc_vld), .y(yc)
    );

    assign all_vld = ya_vld & yb_vld & yc_vld;

    // Next state, unit launch and result capture.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        x_vld   = 1'b0;
        unique case (state_q)
            IDLE: begin
                x_vld = arg_vld;
                if (arg_vld) state_d = WAIT_SQRT;
            end
            WAIT_SQRT: begin
                if (all_vld) begin
                    res_d   = RES_W'(ya) + RES_W'(yb) + RES_W'(yc);
                    state_d = OUTPUT;
                end
            end
            OUTPUT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    assign res_vld = (state_q == OUTPUT);
    assign res     = res_q;

endmodule

// File: tb/tb_formula_1_impl_1.sv
// Self-checking bench for formula_1_impl_1: table vectors, corner
// sequences and random triples against a binary-search isqrt model.
module tb_formula_1_impl_1;

    logic        clk = 1'b0;
    logic        rst;
    logic        arg_vld;
    logic [31:0] a, b, c;
    logic        res_vld;
    logic [31:0] res;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    formula_1_impl_1 dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld),
        .a(a), .b(b), .c(c),
        .res_vld(res_vld), .res(res)
    );

    always #5 clk = ~clk;

    function automatic longint ref_isqrt(input longint x);
        longint lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [31:0] ref_sum(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [31:0] z);
        longint s;
        s = ref_isqrt(longint'(x)) + ref_isqrt(longint'(y))
          + ref_isqrt(longint'(z));
        return 32'(s);
    endfunction

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one request and return cycles until res_vld (0 on timeout).
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] ic, output int lat);
        a = ia;
        b = ib;
        c = ic;
        arg_vld = 1'b1;
        tick();
        arg_vld = 1'b0;
        lat = 1;
        while (!res_vld && lat < 1000) begin
            tick();
            lat++;
        end
        if (!res_vld) lat = 0;
    endtask

    task automatic run_req(input string name, input logic [31:0] ia,
                           input logic [31:0] ib, input logic [31:0] ic,
                           input logic [31:0] exp);
        int lat;
        logic [31:0] got;
        issue(ia, ib, ic, lat);
        check({name, " latency"}, lat, 18);
        check({name, " res"}, res, exp);
        got = res;
        tick();
        check({name, " strobe width"}, res_vld, 0);
        check({name, " res held"}, res, got);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (res_vld) n++;
            tick();
        end
    endtask

    initial begin
        int lat, n;
        logic [31:0] ra, rb, rc;

        vecs[0] = '{32'd1, 32'd4, 32'd9, 32'd6};
        vecs[1] = '{32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2] = '{32'd1, 32'd1, 32'd1, 32'd3};
        vecs[3] = '{32'd4, 32'd4, 32'd4, 32'd6};
        vecs[4] = '{32'd13, 32'd13, 32'd13, 32'd9};
        vecs[5] = '{32'd40, 32'd40, 32'd40, 32'd18};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'd196605};
        vecs[7] = '{32'd15, 32'd16, 32'd24, 32'd11};

        rst = 1'b1;
        arg_vld = 1'b1;
        a = 'x;
        b = 'x;
        c = 'x;
        repeat (3) tick();
        check("reset res_vld", res_vld, 0);
        check("reset res", res, 0);
        arg_vld = 1'b0;
        a = '0;
        b = '0;
        c = '0;
        rst = 1'b0;
        count_pulses(30, n);
        check("no pulse after reset", n, 0);

        foreach (vecs[i])
            run_req($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].c, vecs[i].exp);

        a = 32'd100;
        b = 32'd100;
        c = 32'd100;
        arg_vld = 1'b1;
        tick();
        arg_vld = 1'b0;
        repeat (5) tick();
        a = 32'd1;
        b = 32'd1;
        c = 32'd1;
        arg_vld = 1'b1;
        tick();
        arg_vld = 1'b0;
        lat = 0;
        while (!res_vld && lat < 100) begin
            tick();
            lat++;
        end
        check("busy drop first res", res, 30);
        arg_vld = 1'b1;
        a = 32'd9;
        tick();
        arg_vld = 1'b0;
        count_pulses(60, n);
        check("busy drop pulses", n, 0);
        check("busy drop res kept", res, 30);

        a = 32'd49;
        b = 32'd49;
        c = 32'd49;
        arg_vld = 1'b1;
        tick();
        arg_vld = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_pulses(40, n);
        check("abort pulses", n, 0);
        check("abort res", res, 0);

        run_req("post abort", 32'd25, 32'd36, 32'd49, 32'd18);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            rc = $urandom >> $urandom_range(0, 31);
            run_req($sformatf("rand%0d", i), ra, rb, rc,
                    ref_sum(ra, rb, rc));
        end
        count_pulses(30, n);
        check("none pending", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
